// File: rtl/hazard_pkg.sv
// Shared definitions for the EX-stage hazard controller: FSM encoding,
// forwarding select bit positions and the register-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int unsigned FWD_RS1 = 0;
    localparam int unsigned FWD_RS2 = 1;

    // True when a source operand actually read by ID is produced by the EX instruction.
    // No x0 check: the decoder never sets regwrite for rd=0.
    function automatic logic src_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic       ex_wr,
                                       input logic [4:0] ex_dst);
        return use_src & ex_wr & (ex_dst == src);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count events, holding at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/exe_hazard_ctl.sv
// Hazard controller between ID and the EX/MEM-WB back end: load-use stall,
// redirect flush, registered forwarding selects and bubble flag, event counters.
module exe_hazard_ctl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             ex_redirect,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             nos,
    output logic [1:0]       exe_forwarding,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e     state_q, state_d;
    logic [4:0] ex_rd_q;
    logic       ex_regwrite_q;
    logic       ex_memtoreg_q;
    logic       nos_q;
    logic [1:0] fwd_q, fwd_d;

    logic m1, m2, lu, bubble_next;

    // Hazard detection from the ID operands against the instruction now in EX.
    always_comb begin
        m1          = src_match(id_use_rs1, id_rs1, ex_regwrite_q, ex_rd_q);
        m2          = src_match(id_use_rs2, id_rs2, ex_regwrite_q, ex_rd_q);
        lu          = id_valid & ex_memtoreg_q & (m1 | m2);
        // Redirect takes priority: the stalled consumer is being squashed anyway.
        if_id_flush = ex_redirect;
        if_id_hold  = lu & ~ex_redirect;
        bubble_next = ex_redirect | lu | ~id_valid;
        fwd_d       = 2'b00;
        if (!bubble_next) begin
            fwd_d[FWD_RS1] = m1;
            fwd_d[FWD_RS2] = m2;
        end
    end

    // Next-state logic for the stall/flush sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    state_d = FLUSH;
                end else if (lu) begin
                    state_d = LSTALL;
                end
            end
            LSTALL:  state_d = ex_redirect ? FLUSH : RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State register plus EX tracking; a bubble entering EX clears the tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            nos_q         <= 1'b1;
            fwd_q         <= 2'b00;
            ex_rd_q       <= 5'd0;
            ex_regwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nos_q   <= bubble_next;
            fwd_q   <= fwd_d;
            if (bubble_next) begin
                ex_rd_q       <= 5'd0;
                ex_regwrite_q <= 1'b0;
                ex_memtoreg_q <= 1'b0;
            end else begin
                ex_rd_q       <= id_rd;
                ex_regwrite_q <= id_regwrite;
                ex_memtoreg_q <= id_memtoreg;
            end
        end
    end

    assign nos            = nos_q;
    assign exe_forwarding = fwd_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_hold),
        .count (stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ex_redirect),
        .count (flush_cnt)
    );

endmodule

// File: doc/exe_hazard_ctl.md
# exe_hazard_ctl

Pipeline hazard controller for the two-stage back end (EX → MEM/WB). It sits between the ID-stage decoder and STAGE2. Each cycle it:
- tracks the instruction entering EX;
- produces the registered `EXE_forwarding` select and the `NOS` bubble flag consumed by the EX stage;
- stalls IF/ID on load-use hazards and flushes IF/ID on redirects resolved in EX;
- keeps saturating stall and flush event counters.

## Interface
- `CNT_W`, 16: width of the stall/flush performance counters.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5  ID source register indices.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction reads rs1 / rs2 (rs2 also covers store data).
- `id_rd`  in  5  ID destination register.
- `id_regwrite`, `id_memtoreg`  in  1  ID control bits. The decoder guarantees `id_regwrite=0` whenever `id_rd=0`.
- `ex_redirect`  in  1  taken branch/jump resolved in EX this cycle.
- `if_id_hold`  out  1  combinational: hold PC and IF/ID this cycle.
- `if_id_flush`  out  1  combinational: squash the IF/ID contents at the next edge.
- `nos`  out  1  registered: the instruction now in EX is a bubble; drives STAGE2 `NOS`.
- `exe_forwarding`  out  2  registered: bit0 selects WriteData for rs1, bit1 for rs2; drives STAGE2 `EXE_forwarding_in`.
- `stall_cnt`, `flush_cnt`  out  `CNT_W`  event counters.

## Operation
**EX tracking state.** Internal registers `ex_rd`, `ex_regwrite`, `ex_memtoreg` describe the instruction currently in EX. They are cleared whenever a bubble enters EX.

**Hazard terms (combinational, from ID inputs and EX tracking state):**
- `m1 = id_use_rs1 & ex_regwrite & (ex_rd == id_rs1)`; `m2` is the same for rs2.
- No x0 compare is performed; the decoder guarantees `regwrite=0` for x0.
- `lu = id_valid & ex_memtoreg & (m1 | m2)`: load-use hazard.

**Outputs and next-state decisions:**
- `if_id_flush = ex_redirect`.
- `if_id_hold = lu & ~ex_redirect`. Redirect wins over load-use.
- `bubble_next = ex_redirect | lu | ~id_valid`.
- At the next edge: `nos <= bubble_next`.
- At the next edge, `exe_forwarding <= bubble_next ? 2'b00 : {m2, m1}`. Loads never set forwarding: a load-use case always takes the stall path instead.
- EX tracking state advances from `id_*`, or is cleared when `bubble_next`.

**FSM** (state register, 2 bits):
- `RUN`:
  - `ex_redirect` → `FLUSH`;
  - else `lu` → `LSTALL`;
  - else stay in `RUN`.
- `LSTALL`, exactly one cycle:
  - `ex_redirect` → `FLUSH`;
  - else → `RUN`.
  - The load has left EX, so `lu` cannot re-assert for the same pair.
  - The stalled consumer reads the register file the following cycle. The register file is write-first.
- `FLUSH`, exactly one cycle: → `RUN`. The killed ID slot arrives as `id_valid=0` and produces no further hazard.
- A second `ex_redirect` while in `FLUSH` is impossible, because EX holds a bubble.

**Counters:**
- `stall_cnt` increments on each cycle `if_id_hold=1`.
- `flush_cnt` increments on each cycle `ex_redirect=1`.
- Both saturate at all-ones.

**Reset** (asynchronous, any time, including mid-stall or mid-flush):
- state = `RUN`, `nos=1`, `exe_forwarding=00`;
- EX tracking state cleared;
- both counters 0.
- Combinational outputs follow the cleared state immediately.

## Timing
- Hazard detection is zero-latency: `if_id_hold` and `if_id_flush` are valid in the same cycle as their inputs.
- `nos` and `exe_forwarding` have 1-cycle latency: computed while the instruction is in ID, valid for its whole EX cycle.
- Load-use penalty is exactly 1 bubble. Redirect penalty is exactly 1 bubble in EX, plus the IF flush.
- A counter increment is visible one edge after the triggering cycle.

## Structure
- Shared package `hazard_pkg`:
  - FSM state encoding: `RUN=2'd0`, `LSTALL=2'd1`, `FLUSH=2'd2`;
  - forwarding bit positions: `FWD_RS1=0`, `FWD_RS2=1`.
- One sub-module, `sat_counter` (parameter `W`, inputs `inc`/`rst`), instantiated twice.
- The rest is flat.

## Test plan
- **Reset:** assert `rst` mid-`LSTALL` → immediately `nos=1`, `exe_forwarding=00`, both counters 0, state `RUN`; after release with `id_valid=0` → `nos` stays 1.
- **ALU RAW:** `add x5` (regwrite=1, memtoreg=0) in ID, next cycle `sub` reading rs1=x5, rs2=x5 → `exe_forwarding=2'b11` and `nos=0` during the sub's EX cycle; no hold.
- **Load-use:** `lw x7` then `add` with rs2=x7 → `if_id_hold=1` for exactly 1 cycle, `nos=1` next cycle, `stall_cnt=1`, then add enters EX with `exe_forwarding=00`.
- **Redirect vs load-use:** `ex_redirect=1` in the same cycle as `lu=1` → `if_id_hold=0`, `if_id_flush=1`, state `FLUSH`, `flush_cnt +1`, `stall_cnt` unchanged.
- **Non-user:** `lw x3` then an instruction with `id_use_rs1=0`, `id_rs1=3` → no stall, `exe_forwarding=00`.
- **Saturation:** with `CNT_W=4`, 20 consecutive load-use pairs → `stall_cnt` holds at 15.
